stopwatch_display_scan: RTL

Time-multiplexed six-digit seven-segment driver sitting directly downstream of `stopwatch`. It consumes the packed BCD `disp_time` bus (MM:SS:hh) and scans it onto a common-anode display, one digit at a time. A shadow copy of `disp_time` is captured once per frame, so a digit rollover mid-scan never produces a torn reading.

---
 rtl/stopwatch_disp_pkg.sv | 41 ++++
 rtl/stopwatch_display_scan_bcd_to_seg7.sv | 34 +++
 rtl/stopwatch_display_scan.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/stopwatch_disp_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_disp_pkg
//
// Shared constants for the stopwatch seven-segment scan driver.
//   NUM_DIGITS  : number of multiplexed digits (MM:SS:hh = 6)
//   SEG_*       : active-low segment patterns, bit order {g,f,e,d,c,b,a}
//   DP_MASK     : active-low decimal-point pattern indexed by digit slot;
//                 zeros sit after the minutes and seconds digits.
//   AN_OFF      : all digit enables inactive (active-low)
// -----------------------------------------------------------------------------
package stopwatch_disp_pkg;

   localparam int NUM_DIGITS = 6;

   localparam logic [6:0] SEG_0    = 7'b1000000;
   localparam logic [6:0] SEG_1    = 7'b1111001;
   localparam logic [6:0] SEG_2    = 7'b0100100;
   localparam logic [6:0] SEG_3    = 7'b0110000;
   localparam logic [6:0] SEG_4    = 7'b0011001;
   localparam logic [6:0] SEG_5    = 7'b0010010;
   localparam logic [6:0] SEG_6    = 7'b0000010;
   localparam logic [6:0] SEG_7    = 7'b1111000;
   localparam logic [6:0] SEG_8    = 7'b0000000;
   localparam logic [6:0] SEG_9    = 7'b0010000;
   localparam logic [6:0] SEG_DASH = 7'b0111111;
   localparam logic [6:0] SEG_OFF  = 7'b1111111;

   localparam logic [NUM_DIGITS-1:0] DP_MASK = 6'b101011;
   localparam logic [NUM_DIGITS-1:0] AN_OFF  = 6'b111111;

   typedef logic [2:0] digit_idx_t;

   // Next scan slot: 0,1,...,NUM_DIGITS-1,0,...
   function automatic digit_idx_t next_digit(input digit_idx_t cur);
      if (cur == digit_idx_t'(NUM_DIGITS - 1)) begin
         return '0;
      end
      return cur + digit_idx_t'(1);
   endfunction

endpackage

// File: rtl/stopwatch_display_scan_bcd_to_seg7.sv
// -----------------------------------------------------------------------------
// bcd_to_seg7
//
// Purely combinational BCD to seven-segment decoder.
//   nibble : in  4  BCD digit
//   seg    : out 7  active-low segments {g,f,e,d,c,b,a}
// Codes 4'hA..4'hF are not valid BCD and show a dash so that an upstream
// counter fault is visible on the display instead of being silently masked.
// -----------------------------------------------------------------------------
module bcd_to_seg7
   import stopwatch_disp_pkg::*;
(
   input  logic [3:0] nibble,
   output logic [6:0] seg
);

   always_comb begin
      seg = SEG_DASH;
      case (nibble)
         4'd0:    seg = SEG_0;
         4'd1:    seg = SEG_1;
         4'd2:    seg = SEG_2;
         4'd3:    seg = SEG_3;
         4'd4:    seg = SEG_4;
         4'd5:    seg = SEG_5;
         4'd6:    seg = SEG_6;
         4'd7:    seg = SEG_7;
         4'd8:    seg = SEG_8;
         4'd9:    seg = SEG_9;
         default: seg = SEG_DASH;
      endcase
   end

endmodule

// File: rtl/stopwatch_display_scan.sv
// -----------------------------------------------------------------------------
// stopwatch_display_scan
//
// Time-multiplexed six-digit common-anode driver for the stopwatch MM:SS:hh
// readout. A shadow copy of disp_time is taken once per frame so a rollover
// in the middle of a scan never shows a torn value.
//
// Parameters:
//   REFRESH_DIV : clock cycles each digit stays lit (2..65535)
// Ports:
//   clk       : in  1   system clock (same as the stopwatch core)
//   reset     : in  1   asynchronous, active-high reset
//   disp_time : in  24  packed BCD {m10,m1,s10,s1,h10,h1}
//   an        : out 6   digit enables, active-low; an[i] shows disp_time[4i+3:4i]
//   seg       : out 7   segments {g,f,e,d,c,b,a}, active-low
//   dp        : out 1   decimal point, active-low
//
// Build option:
//   STOPWATCH_DISP_LZB_EN : when defined, leading-zero blanking of the two
//                           minute digits is enabled.
// -----------------------------------------------------------------------------
module stopwatch_display_scan
   import stopwatch_disp_pkg::*;
#(
   parameter int unsigned REFRESH_DIV = 50000
)
(
   input  logic        clk,
   input  logic        reset,
   input  logic [23:0] disp_time,
   output logic [5:0]  an,
   output logic [6:0]  seg,
   output logic        dp
);

   localparam logic [15:0] CNT_LAST = 16'(REFRESH_DIV - 1);

   logic [15:0] cnt_q, cnt_d;
   digit_idx_t  idx_q, idx_d;
   logic [23:0] shadow_q, shadow_d;
   logic        started_q, started_d;
   logic [5:0]  an_q, an_d;
   logic [6:0]  seg_q, seg_d;
   logic        dp_q, dp_d;

   logic        tick;
   logic [3:0]  cur_nib;
   logic [6:0]  cur_seg;
   logic        blank_digit;
   logic [3:0]  nib_arr [NUM_DIGITS];

   // Split the shadow word into per-digit nibbles.
   generate
      for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_nib
         assign nib_arr[gi] = shadow_q[4*gi +: 4];
      end
   endgenerate

   // Refresh divider, digit index and frame snapshot.
   always_comb begin
      tick      = (cnt_q == CNT_LAST);
      cnt_d     = tick ? 16'd0 : cnt_q + 16'd1;
      idx_d     = idx_q;
      shadow_d  = shadow_q;
      started_d = started_q;
      if (tick) begin
         idx_d     = next_digit(idx_q);
         started_d = 1'b1;
         // Wrapping from the last slot starts a new frame: latch the time.
         if (idx_q == digit_idx_t'(NUM_DIGITS - 1)) begin
            shadow_d = disp_time;
         end
      end
   end

   // Nibble mux in front of the single shared decoder.
   always_comb begin
      cur_nib = 4'd0;
      for (int i = 0; i < NUM_DIGITS; i++) begin
         if (idx_q == digit_idx_t'(i)) begin
            cur_nib = nib_arr[i];
         end
      end
   end

   bcd_to_seg7 u_dec (
      .nibble (cur_nib),
      .seg    (cur_seg)
   );

`ifdef STOPWATCH_DISP_LZB_EN
   // Minute tens hidden when zero; minute ones hidden only when both minute
   // digits are zero, so "05:12.xx" stays readable as "5:12.xx".
   always_comb begin
      blank_digit = 1'b0;
      if (idx_q == 3'd5 && nib_arr[5] == 4'd0) begin
         blank_digit = 1'b1;
      end
      if (idx_q == 3'd4 && nib_arr[5] == 4'd0 && nib_arr[4] == 4'd0) begin
         blank_digit = 1'b1;
      end
   end
`else
   assign blank_digit = 1'b0;
`endif

   // Output pattern for the current slot. Until the first tick after reset
   // the shadow holds no captured time, so the display stays dark; the first
   // lit digit is therefore digit 0 of the first real frame.
   always_comb begin
      an_d  = AN_OFF;
      seg_d = SEG_OFF;
      dp_d  = 1'b1;
      if (started_q && !blank_digit) begin
         for (int i = 0; i < NUM_DIGITS; i++) begin
            if (idx_q == digit_idx_t'(i)) begin
               an_d[i] = 1'b0;
               dp_d    = DP_MASK[i];
            end
         end
         seg_d = cur_seg;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q     <= 16'd0;
         idx_q     <= digit_idx_t'(NUM_DIGITS - 1);
         shadow_q  <= 24'h0;
         started_q <= 1'b0;
         an_q      <= AN_OFF;
         seg_q     <= SEG_OFF;
         dp_q      <= 1'b1;
      end else begin
         cnt_q     <= cnt_d;
         idx_q     <= idx_d;
         shadow_q  <= shadow_d;
         started_q <= started_d;
         an_q      <= an_d;
         seg_q     <= seg_d;
         dp_q      <= dp_d;
      end
   end

   assign an  = an_q;
   assign seg = seg_q;
   assign dp  = dp_q;

endmodule
